// File: rtl/uart_cmd_processor.sv
// UART command processor: serial RX -> command FSM (register file / ALU) -> serial TX responses.
// Optional macro ALU_WIDE_EN: 16-bit ALU result, sent as low byte then high byte.
module uart_cmd_processor #(
    parameter int unsigned OS_DIV     = 14,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RF_DEPTH   = 16
) (
    input  logic REF_CLK,
    input  logic RST_N,
    input  logic UART_RX_IN,
    output logic UART_TX_OUT,
    output logic Parity_Error,
    output logic Framing_Error
);
    localparam int unsigned DW  = DATA_WIDTH;
    localparam int unsigned AW  = $clog2(RF_DEPTH);
    localparam int unsigned IW  = $clog2(DW);
    localparam int unsigned OSW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
`ifdef ALU_WIDE_EN
    localparam int unsigned RW  = 2 * DW;
`else
    localparam int unsigned RW  = DW;
`endif

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP, TX_GAP} tx_state_t;
    typedef enum logic [3:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB, ALU_FUN,
                              ALU_RUN, TX_SEND} cmd_state_t;

    logic [DW-1:0] mem [RF_DEPTH];

    function automatic logic [5:0] decode_ps(input logic [5:0] f);
        case (f)
            6'd8, 6'd16: return f;
            default:     return 6'd32;
        endcase
    endfunction

    logic [OSW-1:0] os_cnt;
    logic           tick;

    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            os_cnt <= '0;
            tick   <= 1'b0;
        end else if (os_cnt == OSW'(OS_DIV - 1)) begin
            os_cnt <= '0;
            tick   <= 1'b1;
        end else begin
            os_cnt <= os_cnt + OSW'(1);
            tick   <= 1'b0;
        end
    end

    // ---------------- receiver ----------------
    logic [1:0]    rx_sync;
    logic          rx_s;
    rx_state_t     rx_st;
    logic [5:0]    rx_cnt, rx_ps;
    logic [IW-1:0] rx_idx;
    logic [DW-1:0] rx_sh, rx_byte;
    logic          rx_pen, rx_ptyp, rx_perr, rx_valid;

    assign rx_s = rx_sync[1];

    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_sync       <= 2'b11;
            rx_st         <= RX_IDLE;
            rx_cnt        <= '0;
            rx_ps         <= 6'd32;
            rx_idx        <= '0;
            rx_sh         <= '0;
            rx_byte       <= '0;
            rx_pen        <= 1'b0;
            rx_ptyp       <= 1'b0;
            rx_perr       <= 1'b0;
            rx_valid      <= 1'b0;
            Parity_Error  <= 1'b0;
            Framing_Error <= 1'b0;
        end else begin
            rx_sync       <= {rx_sync[0], UART_RX_IN};
            rx_valid      <= 1'b0;
            Parity_Error  <= 1'b0;
            Framing_Error <= 1'b0;
            if (rx_st == RX_IDLE) begin
                if (!rx_s) begin
                    rx_ps   <= decode_ps(mem[2][7:2]);
                    rx_pen  <= mem[2][0];
                    rx_ptyp <= mem[2][1];
                    rx_perr <= 1'b0;
                    rx_cnt  <= '0;
                    rx_st   <= RX_START;
                end
            end else if (tick) begin
                rx_cnt <= (rx_cnt == rx_ps - 6'd1) ? '0 : rx_cnt + 6'd1;
                if (rx_cnt == (rx_ps >> 1) - 6'd1) begin
                    case (rx_st)
                        RX_START: if (rx_s) rx_st <= RX_IDLE;
                        RX_DATA:  rx_sh <= {rx_s, rx_sh[DW-1:1]};
                        RX_PAR:   rx_perr <= rx_s != ((^rx_sh) ^ rx_ptyp);
                        RX_STOP: begin
                            // leave mid-stop so a back-to-back start edge is not missed
                            rx_st         <= RX_IDLE;
                            Parity_Error  <= rx_pen & rx_perr;
                            Framing_Error <= !rx_s;
                            rx_valid      <= rx_s & !(rx_pen & rx_perr);
                            rx_byte       <= rx_sh;
                        end
                        default: ;
                    endcase
                end
                if (rx_cnt == rx_ps - 6'd1) begin
                    case (rx_st)
                        RX_START: begin
                            rx_st  <= RX_DATA;
                            rx_idx <= '0;
                        end
                        RX_DATA:
                            if (rx_idx == IW'(DW - 1)) rx_st <= rx_pen ? RX_PAR : RX_STOP;
                            else                       rx_idx <= rx_idx + IW'(1);
                        RX_PAR:  rx_st <= RX_STOP;
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- transmitter ----------------
    tx_state_t     tx_st;
    logic [5:0]    tx_cnt, tx_ps;
    logic [IW-1:0] tx_idx;
    logic [DW-1:0] tx_sh, tx_data;
    logic          tx_pen, tx_par, tx_out_v, tx_load, tx_busy;

    assign tx_busy = tx_out_v || (tx_st != TX_IDLE);

    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_st       <= TX_IDLE;
            UART_TX_OUT <= 1'b1;
            tx_out_v    <= 1'b0;
            tx_cnt      <= '0;
            tx_ps       <= 6'd32;
            tx_idx      <= '0;
            tx_sh       <= '0;
            tx_pen      <= 1'b0;
            tx_par      <= 1'b0;
        end else begin
            case (tx_st)
                TX_IDLE: if (tx_load) begin
                    tx_sh  <= tx_data;
                    tx_pen <= mem[2][0];
                    tx_par <= (^tx_data) ^ mem[2][1];
                    tx_ps  <= decode_ps(mem[2][7:2]);
                    tx_st  <= TX_WAIT;
                end
                TX_WAIT: if (tick) begin
                    tx_st       <= TX_START;
                    UART_TX_OUT <= 1'b0;
                    tx_out_v    <= 1'b1;
                    tx_cnt      <= '0;
                end
                default: if (tick) begin
                    if (tx_cnt != tx_ps - 6'd1) begin
                        tx_cnt <= tx_cnt + 6'd1;
                    end else begin
                        tx_cnt <= '0;
                        case (tx_st)
                            TX_START: begin
                                tx_st       <= TX_DATA;
                                tx_idx      <= '0;
                                UART_TX_OUT <= tx_sh[0];
                            end
                            TX_DATA:
                                if (tx_idx == IW'(DW - 1)) begin
                                    tx_st       <= tx_pen ? TX_PAR : TX_STOP;
                                    UART_TX_OUT <= tx_pen ? tx_par : 1'b1;
                                end else begin
                                    tx_idx      <= tx_idx + IW'(1);
                                    tx_sh       <= tx_sh >> 1;
                                    UART_TX_OUT <= tx_sh[1];
                                end
                            TX_PAR: begin
                                tx_st       <= TX_STOP;
                                UART_TX_OUT <= 1'b1;
                            end
                            TX_STOP: begin
                                tx_st    <= TX_GAP;
                                tx_out_v <= 1'b0;
                            end
                            default: tx_st <= TX_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // ---------------- ALU ----------------
    logic [DW-1:0]   opa, opb;
    logic [2*DW-1:0] prod;
    logic [3:0]      fun;
    logic [RW-1:0]   alu_res;

    assign opa  = mem[0];
    assign opb  = mem[1];
    assign prod = {{DW{1'b0}}, opa} * {{DW{1'b0}}, opb};

    always_comb begin
        alu_res = '0;
        case (fun)
            4'h0: alu_res = RW'(opa + opb);
            4'h1: alu_res = RW'(opa - opb);
            4'h2: alu_res = RW'(prod);
            4'h3: alu_res = (opb == '0) ? RW'({DW{1'b1}}) : RW'(opa / opb);
            4'h4: alu_res = RW'(opa & opb);
            4'h5: alu_res = RW'(opa | opb);
            4'h6: alu_res = RW'(~(opa & opb));
            4'h7: alu_res = RW'(~(opa | opb));
            4'h8: alu_res = RW'(opa ^ opb);
            4'h9: alu_res = RW'(~(opa ^ opb));
            4'hA: alu_res = RW'(opa == opb);
            4'hB: alu_res = RW'(opa > opb);
            4'hC: alu_res = RW'(opa < opb);
            4'hD: alu_res = RW'(opa >> 1);
            4'hE: alu_res = RW'(opa << 1);
            default: alu_res = '0;
        endcase
    end

    // ---------------- command FSM ----------------
    cmd_state_t    state;
    logic          pend, tx_two;
    logic [DW-1:0] pend_byte, tx_byte, tx_hi;
    logic [AW-1:0] addr;

    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            pend      <= 1'b0;
            pend_byte <= '0;
            addr      <= '0;
            fun       <= '0;
            tx_byte   <= '0;
            tx_hi     <= '0;
            tx_two    <= 1'b0;
            tx_load   <= 1'b0;
            tx_data   <= '0;
            for (int unsigned i = 0; i < RF_DEPTH; i++) mem[i] <= '0;
            mem[2] <= DW'(8'h81);
            mem[3] <= DW'(8'h20);
        end else begin
            tx_load <= 1'b0;
            case (state)
                IDLE: if (pend) begin
                    pend <= 1'b0;
                    case (pend_byte)
                        8'hAA:   state <= WR_ADDR;
                        8'hBB:   state <= RD_ADDR;
                        8'hCC:   state <= ALU_OPA;
                        8'hDD:   state <= ALU_FUN;
                        default: state <= IDLE;
                    endcase
                end
                WR_ADDR: if (pend) begin
                    pend  <= 1'b0;
                    addr  <= pend_byte[AW-1:0];
                    state <= WR_DATA;
                end
                WR_DATA: if (pend) begin
                    pend      <= 1'b0;
                    mem[addr] <= pend_byte;
                    state     <= IDLE;
                end
                RD_ADDR: if (pend) begin
                    pend    <= 1'b0;
                    tx_byte <= mem[pend_byte[AW-1:0]];
                    tx_two  <= 1'b0;
                    state   <= TX_SEND;
                end
                ALU_OPA: if (pend) begin
                    pend   <= 1'b0;
                    mem[0] <= pend_byte;
                    state  <= ALU_OPB;
                end
                ALU_OPB: if (pend) begin
                    pend   <= 1'b0;
                    mem[1] <= pend_byte;
                    state  <= ALU_FUN;
                end
                ALU_FUN: if (pend) begin
                    pend  <= 1'b0;
                    fun   <= pend_byte[3:0];
                    state <= ALU_RUN;
                end
                ALU_RUN: begin
                    tx_byte <= alu_res[DW-1:0];
`ifdef ALU_WIDE_EN
                    tx_hi   <= alu_res[RW-1:DW];
                    tx_two  <= 1'b1;
`else
                    tx_hi   <= '0;
                    tx_two  <= 1'b0;
`endif
                    state   <= TX_SEND;
                end
                default: if (!tx_busy && !tx_load) begin
                    // tx_load blocks a reload in the cycle before the TX reports busy
                    tx_load <= 1'b1;
                    tx_data <= tx_byte;
                    if (tx_two) begin
                        tx_byte <= tx_hi;
                        tx_two  <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
            if (rx_valid) begin
                pend      <= 1'b1;
                pend_byte <= rx_byte;
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_processor.sv
// Directed bench for uart_cmd_processor: register write/read, ALU vector table, RX errors, config changes.
module tb_uart_cmd_processor;
    localparam int unsigned OSD = 2;

    logic REF_CLK = 1'b0;
    logic RST_N;
    logic UART_RX_IN;
    logic UART_TX_OUT;
    logic Parity_Error;
    logic Framing_Error;

    always #5 REF_CLK = ~REF_CLK;

    uart_cmd_processor #(.OS_DIV(OSD), .DATA_WIDTH(8), .RF_DEPTH(16)) dut (
        .REF_CLK      (REF_CLK),
        .RST_N        (RST_N),
        .UART_RX_IN   (UART_RX_IN),
        .UART_TX_OUT  (UART_TX_OUT),
        .Parity_Error (Parity_Error),
        .Framing_Error(Framing_Error)
    );

    int   checks = 0;
    int   errors = 0;
    int   tb_ps = 32;
    logic tb_pen = 1'b1;
    logic tb_ptyp = 1'b0;

    int   perr_cnt = 0;
    int   ferr_cnt = 0;
    int   tx_falls = 0;
    logic tx_prev = 1'b1;

    always @(negedge REF_CLK) begin
        if (Parity_Error === 1'b1) perr_cnt++;
        if (Framing_Error === 1'b1) ferr_cnt++;
        if (tx_prev === 1'b1 && UART_TX_OUT === 1'b0) tx_falls++;
        tx_prev = UART_TX_OUT;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] fun;
        logic [7:0] exp;
    } alu_vec_t;

    alu_vec_t vec [17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge REF_CLK);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic flip_par, input logic stop_low);
        int bc;
        bc = tb_ps * OSD;
        UART_RX_IN = 1'b0;
        wait_clks(bc);
        for (int i = 0; i < 8; i++) begin
            UART_RX_IN = d[i];
            wait_clks(bc);
        end
        if (tb_pen) begin
            UART_RX_IN = (^d) ^ tb_ptyp ^ flip_par;
            wait_clks(bc);
        end
        if (stop_low) begin
            UART_RX_IN = 1'b0;
            wait_clks(bc * 3 / 4);
        end
        UART_RX_IN = 1'b1;
        wait_clks(bc);
    endtask

    task automatic expect_tx(input logic [7:0] exp, input string nm);
        int         bc;
        int         n;
        logic [7:0] got;
        bc = tb_ps * OSD;
        n  = 0;
        while (UART_TX_OUT !== 1'b0 && n < 40 * bc) begin
            @(negedge REF_CLK);
            n++;
        end
        if (UART_TX_OUT !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: no TX start bit within %0d cycles, line=%b expected 0", nm, n, UART_TX_OUT);
        end else begin
            wait_clks(bc / 2);
            check({nm, " start"}, UART_TX_OUT, 1'b0);
            for (int i = 0; i < 8; i++) begin
                wait_clks(bc);
                got[i] = UART_TX_OUT;
            end
            check({nm, " data"}, got, exp);
            if (tb_pen) begin
                wait_clks(bc);
                check({nm, " parity"}, UART_TX_OUT, (^exp) ^ tb_ptyp);
            end
            wait_clks(bc);
            check({nm, " stop"}, UART_TX_OUT, 1'b1);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pe0, fe0, f0, n;
        vec[0]  = '{8'hFF, 8'h02, 4'h0, 8'h01};
        vec[1]  = '{8'h03, 8'h05, 4'h1, 8'hFE};
        vec[2]  = '{8'h10, 8'h11, 4'h2, 8'h10};
        vec[3]  = '{8'h64, 8'h07, 4'h3, 8'h0E};
        vec[4]  = '{8'h12, 8'h00, 4'h3, 8'hFF};
        vec[5]  = '{8'hF0, 8'h3C, 4'h4, 8'h30};
        vec[6]  = '{8'hF0, 8'h3C, 4'h5, 8'hFC};
        vec[7]  = '{8'hF0, 8'h3C, 4'h6, 8'hCF};
        vec[8]  = '{8'hF0, 8'h3C, 4'h7, 8'h03};
        vec[9]  = '{8'hF0, 8'h3C, 4'h8, 8'hCC};
        vec[10] = '{8'hF0, 8'h3C, 4'h9, 8'h33};
        vec[11] = '{8'h55, 8'h55, 4'hA, 8'h01};
        vec[12] = '{8'h56, 8'h55, 4'hB, 8'h01};
        vec[13] = '{8'h56, 8'h55, 4'hC, 8'h00};
        vec[14] = '{8'h81, 8'h00, 4'hD, 8'h40};
        vec[15] = '{8'h81, 8'h00, 4'hE, 8'h02};
        vec[16] = '{8'h81, 8'h00, 4'hF, 8'h00};

        UART_RX_IN = 1'b1;
        RST_N      = 1'b0;
        wait_clks(5);
        check("rst tx_out", UART_TX_OUT, 1'b1);
        check("rst parity_err", Parity_Error, 1'b0);
        check("rst framing_err", Framing_Error, 1'b0);
        RST_N = 1'b1;
        wait_clks(5);
        check("rst reg2", dut.mem[2], 8'h81);
        check("rst reg3", dut.mem[3], 8'h20);
        check("idle tx_out", UART_TX_OUT, 1'b1);

        f0 = tx_falls;
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h0A, 1'b0, 1'b0);
        wait_clks(10);
        check("write mem5", dut.mem[5], 8'h0A);
        check("write no tx", tx_falls - f0, 0);

        send_byte(8'hBB, 1'b0, 1'b0);
        fork
            send_byte(8'h05, 1'b0, 1'b0);
            expect_tx(8'h0A, "read mem5");
        join

        send_byte(8'hCC, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        fork
            send_byte(8'h00, 1'b0, 1'b0);
            expect_tx(8'h03, "alu add");
        join
        check("reg0", dut.mem[0], 8'h01);
        check("reg1", dut.mem[1], 8'h02);

        send_byte(8'hDD, 1'b0, 1'b0);
        fork
            send_byte(8'h02, 1'b0, 1'b0);
            expect_tx(8'h02, "alu fun mul");
        join

        // A parity-errored 0xAA must not move the FSM, so 0xBB is still read as a command.
        pe0 = perr_cnt;
        fe0 = ferr_cnt;
        send_byte(8'hAA, 1'b1, 1'b0);
        wait_clks(4);
        check("parity pulse", perr_cnt - pe0, 1);
        check("parity no framing", ferr_cnt - fe0, 0);
        send_byte(8'hBB, 1'b0, 1'b0);
        fork
            send_byte(8'h03, 1'b0, 1'b0);
            expect_tx(8'h20, "read after perr");
        join

        pe0 = perr_cnt;
        fe0 = ferr_cnt;
        send_byte(8'h55, 1'b0, 1'b1);
        wait_clks(4);
        check("framing pulse", ferr_cnt - fe0, 1);
        check("framing no parity", perr_cnt - pe0, 0);

        // Prescale 16, odd parity: takes effect from the next frame.
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h43, 1'b0, 1'b0);
        wait_clks(10);
        check("cfg reg2 ps16", dut.mem[2], 8'h43);
        tb_ps   = 16;
        tb_ptyp = 1'b1;
        send_byte(8'hBB, 1'b0, 1'b0);
        fork
            send_byte(8'h03, 1'b0, 1'b0);
            expect_tx(8'h20, "read ps16 odd");
        join

        // Prescale 8, parity off.
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h20, 1'b0, 1'b0);
        wait_clks(10);
        tb_ps  = 8;
        tb_pen = 1'b0;

        for (int i = 0; i < 17; i++) begin
            if (i > 0 && vec[i].a == vec[i-1].a && vec[i].b == vec[i-1].b) begin
                send_byte(8'hDD, 1'b0, 1'b0);
            end else begin
                send_byte(8'hCC, 1'b0, 1'b0);
                send_byte(vec[i].a, 1'b0, 1'b0);
                send_byte(vec[i].b, 1'b0, 1'b0);
            end
            fork
                send_byte({4'h0, vec[i].fun}, 1'b0, 1'b0);
                expect_tx(vec[i].exp, $sformatf("alu vec%0d fun%0h", i, vec[i].fun));
            join
        end

        // Prescale field 12 is unsupported and must behave as 32.
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h31, 1'b0, 1'b0);
        wait_clks(10);
        tb_ps   = 32;
        tb_pen  = 1'b1;
        tb_ptyp = 1'b0;
        send_byte(8'hBB, 1'b0, 1'b0);
        fork
            send_byte(8'h05, 1'b0, 1'b0);
            expect_tx(8'h0A, "read ps fallback");
        join

        // Reset in the middle of a response frame.
        send_byte(8'hBB, 1'b0, 1'b0);
        fork
            send_byte(8'h05, 1'b0, 1'b0);
            begin
                n = 0;
                while (UART_TX_OUT !== 1'b0 && n < 40 * tb_ps * OSD) begin
                    @(negedge REF_CLK);
                    n++;
                end
                check("pre-reset tx start", UART_TX_OUT, 1'b0);
                wait_clks(3 * tb_ps * OSD);
                RST_N = 1'b0;
                #1;
                check("midframe rst tx_out", UART_TX_OUT, 1'b1);
                wait_clks(3);
                check("midframe rst reg2", dut.mem[2], 8'h81);
                check("midframe rst reg5", dut.mem[5], 8'h00);
                RST_N = 1'b1;
            end
        join
        wait_clks(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
